// File: rtl/wave_gen_pkg.sv
// Shared types and helpers for the multimode waveform generator.
//   wave_mode_e : waveform select encoding (matches the 2-bit mode input)
//   start_level : level shown while the generator is held idle
package wave_gen_pkg;

  localparam int MODE_W = 2;
  // Widest level supported by the helper below; callers size-cast to WIDTH.
  localparam int MAX_W  = 32;

  typedef enum logic [MODE_W-1:0] {
    SAW_UP   = 2'd0,
    SAW_DOWN = 2'd1,
    TRIANGLE = 2'd2,
    SQUARE   = 2'd3
  } wave_mode_e;

  // Idle/start level: a falling saw starts from the top, every other shape from 0.
  function automatic logic [MAX_W-1:0] start_level(wave_mode_e mode, logic [MAX_W-1:0] peak);
    return (mode == SAW_DOWN) ? peak : '0;
  endfunction

endpackage

// File: rtl/multimode_wave_generator_if.sv
// Control/output bundle of the multimode waveform generator.
//   enable, mode, peak, step_period : run control, driven by the master
//   level, pwm_out, wrap            : waveform outputs, driven by the generator
//   master modport : controller / testbench side
//   slave modport  : generator side
interface multimode_wave_generator_if
  import wave_gen_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 24
);
  logic                enable;
  logic [MODE_W-1:0]   mode;
  logic [WIDTH-1:0]    peak;
  logic [PERIOD_W-1:0] step_period;
  logic [WIDTH-1:0]    level;
  logic                pwm_out;
  logic                wrap;

  modport master (
    output enable, mode, peak, step_period,
    input  level, pwm_out, wrap
  );

  modport slave (
    input  enable, mode, peak, step_period,
    output level, pwm_out, wrap
  );
endinterface

// File: rtl/multimode_wave_generator_step_timer.sv
// Reload down-counter producing the level-step strobe.
//   clk, reset  : clock, synchronous active-high reset
//   enable      : run enable; while low the counter is preloaded
//   step_period : clocks per step (0 behaves as 1), sampled only at reload
//   tick        : combinational strobe, high when the counter reaches 0
module step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] step_period,
  output logic                tick
);

  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] reload;

  always_comb begin
    // Neff-1 with Neff = max(step_period, 1)
    reload  = (step_period == '0) ? '0 : step_period - PERIOD_W'(1);
    tick    = enable && (timer_q == '0);
    timer_d = timer_q;
    if (!enable || tick) begin
      timer_d = reload;
    end else begin
      timer_d = timer_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/multimode_wave_generator.sv
// Multimode waveform source for an R2R ladder plus a PWM pin.
//   clk, reset : clock, synchronous active-high reset
//   bus.enable : run enable; while low the shadow registers track the inputs
//   bus.mode   : SAW_UP / SAW_DOWN / TRIANGLE / SQUARE
//   bus.peak   : amplitude limit P
//   bus.step_period : clocks per level step
//   bus.level  : current sample, bus.pwm_out : PWM of level,
//   bus.wrap   : one-cycle strobe coincident with the first sample of a period
// Mode and peak are shadowed and only reloaded at a period boundary, so a
// running waveform never shows a partially applied change.
module multimode_wave_generator
  import wave_gen_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic clk,
  input  logic reset,
  multimode_wave_generator_if.slave bus
);

  logic             tick;
  wave_mode_e       mode_in;
  logic [WIDTH:0]   peak_ext;
  logic             wrap_now;

  logic [WIDTH-1:0] level_q, level_d;
  logic             wrap_q, wrap_d;
  wave_mode_e       active_mode_q, active_mode_d;
  logic [WIDTH-1:0] active_peak_q, active_peak_d;
  logic             dir_down_q, dir_down_d;
  logic [WIDTH:0]   sq_cnt_q, sq_cnt_d;
  logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_q, pwm_d;

  assign mode_in  = wave_mode_e'(bus.mode);
  assign peak_ext = {1'b0, active_peak_q};

  step_timer #(.PERIOD_W(PERIOD_W)) u_step_timer (
    .clk         (clk),
    .reset       (reset),
    .enable      (bus.enable),
    .step_period (bus.step_period),
    .tick        (tick)
  );

  always_comb begin
    level_d       = level_q;
    wrap_d        = 1'b0;
    active_mode_d = active_mode_q;
    active_peak_d = active_peak_q;
    dir_down_d    = dir_down_q;
    sq_cnt_d      = sq_cnt_q;
    pwm_cnt_d     = '0;
    pwm_d         = 1'b0;
    wrap_now      = 1'b0;

    if (!bus.enable) begin
      active_mode_d = mode_in;
      active_peak_d = bus.peak;
      level_d       = WIDTH'(start_level(mode_in, MAX_W'(bus.peak)));
      dir_down_d    = 1'b0;
      sq_cnt_d      = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + WIDTH'(1);
      pwm_d     = (pwm_cnt_q < level_q);

      if (tick) begin
        case (active_mode_q)
          SAW_UP: begin
            if (level_q < active_peak_q) level_d = level_q + WIDTH'(1);
            else                         wrap_now = 1'b1;
          end
          SAW_DOWN: begin
            if (level_q != '0) level_d = level_q - WIDTH'(1);
            else               wrap_now = 1'b1;
          end
          TRIANGLE: begin
            if (!dir_down_q) begin
              if (level_q < active_peak_q) begin
                level_d = level_q + WIDTH'(1);
              end else if (active_peak_q <= WIDTH'(1)) begin
                // Peaks of 0 or 1 have no falling half; restart directly.
                wrap_now = 1'b1;
              end else begin
                dir_down_d = 1'b1;
                level_d    = level_q - WIDTH'(1);
              end
            end else begin
              // The falling half stops at 1; the wrap itself supplies the 0.
              if (level_q > WIDTH'(1)) level_d = level_q - WIDTH'(1);
              else                     wrap_now = 1'b1;
            end
          end
          default: begin
            // Square counter spans 0..2P+1; {P,1} is 2P+1 without an adder.
            if (sq_cnt_q == {active_peak_q, 1'b1}) begin
              wrap_now = 1'b1;
            end else begin
              sq_cnt_d = sq_cnt_q + (WIDTH+1)'(1);
              level_d  = (sq_cnt_d <= peak_ext) ? active_peak_q : '0;
            end
          end
        endcase

        if (wrap_now) begin
          wrap_d        = 1'b1;
          active_mode_d = mode_in;
          active_peak_d = bus.peak;
          dir_down_d    = 1'b0;
          sq_cnt_d      = '0;
          // A running square opens its period on the high half (counter 0).
          level_d       = (mode_in == SQUARE) ? bus.peak
                                              : WIDTH'(start_level(mode_in, MAX_W'(bus.peak)));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q       <= '0;
      wrap_q        <= 1'b0;
      active_mode_q <= SAW_UP;
      active_peak_q <= '0;
      dir_down_q    <= 1'b0;
      sq_cnt_q      <= '0;
      pwm_cnt_q     <= '0;
      pwm_q         <= 1'b0;
    end else begin
      level_q       <= level_d;
      wrap_q        <= wrap_d;
      active_mode_q <= active_mode_d;
      active_peak_q <= active_peak_d;
      dir_down_q    <= dir_down_d;
      sq_cnt_q      <= sq_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pwm_q         <= pwm_d;
    end
  end

  assign bus.level   = level_q;
  assign bus.pwm_out = pwm_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_multimode_wave_generator.sv
// Testbench for multimode_wave_generator: directed vector table, hand-written
// corner sequences and randomized stimulus, all checked cycle by cycle against
// a reference model that describes each waveform as a table of one period.
module tb_multimode_wave_generator;
  localparam int WIDTH    = 8;
  localparam int PERIOD_W = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multimode_wave_generator_if #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W)) bus ();

  multimode_wave_generator #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the current period as an explicit list of levels.
  int m_seq[$];
  int m_idx;
  int m_level;
  bit m_wrap;
  bit m_pwm;
  int m_pcnt;
  int m_elapsed;
  int m_neff;

  function void load_period(int mode, int p);
    m_seq.delete();
    case (mode)
      0: for (int i = 0; i <= p; i++) m_seq.push_back(i);
      1: for (int i = p; i >= 0; i--) m_seq.push_back(i);
      2: begin
        for (int i = 0; i <= p; i++) m_seq.push_back(i);
        for (int i = p - 1; i >= 1; i--) m_seq.push_back(i);
      end
      default: begin
        for (int i = 0; i <= p; i++) m_seq.push_back(p);
        for (int i = 0; i <= p; i++) m_seq.push_back(0);
      end
    endcase
    m_idx = 0;
  endfunction

  function void model_step();
    int sp_eff;
    int md;
    int pk;
    sp_eff = (bus.step_period == '0) ? 1 : int'(bus.step_period);
    md     = int'(bus.mode);
    pk     = int'(bus.peak);
    if (reset) begin
      load_period(0, 0);
      m_level = 0; m_wrap = 0; m_pwm = 0; m_pcnt = 0;
      m_elapsed = 0; m_neff = 1;
    end else if (!bus.enable) begin
      load_period(md, pk);
      m_level = (md == 1) ? pk : 0;
      m_wrap = 0; m_pwm = 0; m_pcnt = 0;
      m_elapsed = 0; m_neff = sp_eff;
    end else begin
      m_pwm  = (m_pcnt < m_level);
      m_pcnt = (m_pcnt + 1) % 256;
      m_wrap = 0;
      if (m_elapsed + 1 == m_neff) begin
        m_elapsed = 0;
        m_neff    = sp_eff;
        if (m_idx + 1 == m_seq.size()) begin
          load_period(md, pk);
          m_wrap = 1;
        end else begin
          m_idx++;
        end
        m_level = m_seq[m_idx];
      end else begin
        m_elapsed++;
      end
    end
  endfunction

  task automatic check_model(input string name);
    n_vec++;
    if (bus.level !== 8'(m_level) || bus.wrap !== m_wrap || bus.pwm_out !== m_pwm) begin
      n_bad++;
      $display("FAIL %s t=%0t: level/wrap/pwm got %0d/%0b/%0b want %0d/%0b/%0b",
               name, $time, bus.level, bus.wrap, bus.pwm_out, m_level, m_wrap, m_pwm);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  // One clock: model consumes the current inputs, DUT is sampled 1 ns after the edge.
  task automatic cyc(input string name);
    model_step();
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic set_in(input bit rst, input bit en, input int mode, input int p, input int sp);
    reset           = rst;
    bus.enable      = en;
    bus.mode        = 2'(mode);
    bus.peak        = 8'(p);
    bus.step_period = 24'(sp);
  endtask

  task automatic pwm_window(input string name, input int mode, input int p);
    int highs;
    set_in(0, 0, mode, p, 600);
    cyc(name);
    bus.enable = 1'b1;
    repeat (600) cyc(name);
    expect_int({name, "_level"}, int'(bus.level), (mode == 3) ? p : 0);
    highs = 0;
    repeat (256) begin
      cyc(name);
      highs += int'(bus.pwm_out);
    end
    expect_int({name, "_highs"}, highs, (mode == 3) ? p : 0);
  endtask

  typedef struct {
    bit rst; bit en; int mode; int peak; int sp;
    int lvl; bit wr; bit pw;
  } vec_t;

  vec_t tbl[16];
  int exp_tri[12];
  int exp_shadow[10];
  int exp_step[8];

  initial begin
    set_in(1, 0, 0, 0, 1);

    // SAW_UP P=3 N=2, then P=0 N=0 (wrap every tick)
    tbl[0]  = '{1, 0, 0, 3, 2, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 3, 2, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 3, 2, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 3, 2, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 3, 2, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 3, 2, 2, 0, 0};
    tbl[6]  = '{0, 1, 0, 3, 2, 2, 0, 0};
    tbl[7]  = '{0, 1, 0, 3, 2, 3, 0, 0};
    tbl[8]  = '{0, 1, 0, 3, 2, 3, 0, 0};
    tbl[9]  = '{0, 1, 0, 3, 2, 0, 1, 0};
    tbl[10] = '{0, 1, 0, 3, 2, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 3, 2, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 1, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 1, 0};

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].peak, tbl[i].sp);
      cyc("table_model");
      n_vec++;
      if (bus.level !== 8'(tbl[i].lvl) || bus.wrap !== tbl[i].wr || bus.pwm_out !== tbl[i].pw) begin
        n_bad++;
        $display("FAIL table[%0d]: level/wrap/pwm got %0d/%0b/%0b want %0d/%0b/%0b",
                 i, bus.level, bus.wrap, bus.pwm_out, tbl[i].lvl, tbl[i].wr, tbl[i].pw);
      end
    end

    // TRIANGLE P=3 N=1
    exp_tri = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    set_in(0, 0, 2, 3, 1);
    cyc("tri3");
    bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc("tri3");
      expect_int("tri3_level", int'(bus.level), exp_tri[i]);
      expect_int("tri3_wrap", int'(bus.wrap), (i == 5 || i == 11) ? 1 : 0);
    end

    // TRIANGLE P=1: 0,1,0,1 with wrap on every return to 0
    set_in(0, 0, 2, 1, 1);
    cyc("tri1");
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc("tri1");
      expect_int("tri1_level", int'(bus.level), (i % 2 == 0) ? 1 : 0);
      expect_int("tri1_wrap", int'(bus.wrap), (i % 2 == 1) ? 1 : 0);
    end

    // SAW_DOWN P=4, switch to SQUARE P=2 mid-period
    exp_shadow = '{1, 0, 2, 2, 2, 0, 0, 0, 2, 2};
    set_in(0, 0, 1, 4, 1);
    cyc("shadow");
    expect_int("shadow_start", int'(bus.level), 4);
    bus.enable = 1'b1;
    cyc("shadow");
    cyc("shadow");
    expect_int("shadow_pre", int'(bus.level), 2);
    bus.mode = 2'd3;
    bus.peak = 8'd2;
    for (int i = 0; i < 10; i++) begin
      cyc("shadow");
      expect_int("shadow_level", int'(bus.level), exp_shadow[i]);
      expect_int("shadow_wrap", int'(bus.wrap), (i == 2 || i == 8) ? 1 : 0);
    end

    // step_period 5 -> 2 mid-step: current step keeps 5
    exp_step = '{0, 0, 1, 1, 2, 2, 3, 3};
    set_in(0, 0, 0, 7, 5);
    cyc("step_chg");
    bus.enable = 1'b1;
    cyc("step_chg");
    cyc("step_chg");
    bus.step_period = 24'd2;
    for (int i = 0; i < 8; i++) begin
      cyc("step_chg");
      expect_int("step_chg_level", int'(bus.level), exp_step[i]);
    end

    // PWM duty at levels 0, 128, 255
    pwm_window("pwm0", 0, 0);
    pwm_window("pwm128", 3, 128);
    pwm_window("pwm255", 3, 255);

    // Reset during TRIANGLE falling half, then idle in SAW_DOWN
    set_in(0, 0, 2, 5, 1);
    cyc("rst_mid");
    bus.enable = 1'b1;
    repeat (6) cyc("rst_mid");
    expect_int("rst_mid_down", int'(bus.level), 4);
    reset = 1'b1;
    cyc("rst_mid");
    expect_int("rst_level", int'(bus.level), 0);
    expect_int("rst_wrap", int'(bus.wrap), 0);
    expect_int("rst_pwm", int'(bus.pwm_out), 0);
    set_in(0, 0, 1, 9, 1);
    cyc("idle_sawdown");
    expect_int("idle_level", int'(bus.level), 9);
    expect_int("idle_pwm", int'(bus.pwm_out), 0);

    // Randomized stimulus against the model
    set_in(0, 1, 0, 3, 1);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(24) == 0) begin
        bus.mode = 2'($urandom_range(3));
        bus.peak = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(7));
      end
      if ($urandom_range(19) == 0) bus.step_period = 24'($urandom_range(3));
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
